// File: rtl/mux_gate_arb_pkg.sv
// mux_gate_arb_pkg
// Shared constants for the mux-built gate arbiter:
//   TT_W       width of a gate truth table
//   CNT_W      width of one per-requester grant counter
//   TT_*       truth tables for common gate functions, indexed as tt[{b, a}]
//   wrap_inc   helper returning (idx + 1) mod n
package mux_gate_arb_pkg;

  localparam int TT_W  = 4;
  localparam int CNT_W = 16;

  // Bit index into the table is {b, a}: bit0 = (b=0,a=0) ... bit3 = (b=1,a=1).
  localparam logic [TT_W-1:0] TT_AND    = 4'b1000;
  localparam logic [TT_W-1:0] TT_OR     = 4'b1110;
  localparam logic [TT_W-1:0] TT_XOR    = 4'b0110;
  localparam logic [TT_W-1:0] TT_NOR    = 4'b0001;
  localparam logic [TT_W-1:0] TT_PASS_A = 4'b1010;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux.sv
// mux
// Single-bit 2:1 multiplexer primitive; the only cell used by the gate unit.
// Ports:
//   sel  select (0 -> d0, 1 -> d1)
//   d0   data input chosen when sel = 0
//   d1   data input chosen when sel = 1
//   y    selected output
module mux (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_unit.sv
// mux_logic_unit
// Bitwise programmable logic unit built only from 2:1 mux primitives.
// Every result bit is y[k] = tt[{b[k], a[k]}], so the 4-bit truth table
// picks the gate function (AND, OR, XOR, ...).
// Ports:
//   tt  truth table shared by all bits
//   a   operand A, drives the first mux level select
//   b   operand B, drives the second mux level select
//   y   result
module mux_logic_unit
  import mux_gate_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [TT_W-1:0]  tt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    logic lo;  // tt[{0, a[k]}]
    logic hi;  // tt[{1, a[k]}]

    mux u_lo (
      .sel (a[k]),
      .d0  (tt[0]),
      .d1  (tt[1]),
      .y   (lo)
    );

    mux u_hi (
      .sel (a[k]),
      .d0  (tt[2]),
      .d1  (tt[3]),
      .y   (hi)
    );

    mux u_out (
      .sel (b[k]),
      .d0  (lo),
      .d1  (hi),
      .y   (y[k])
    );
  end

endmodule

// File: rtl/mux_gate_arbiter.sv
// mux_gate_arbiter
// Round-robin arbiter sharing one mux-built logic unit among N_REQ
// requesters. The granted request is evaluated combinationally and the
// result is registered onto a single response channel tagged with the
// requester index.
//
// Optional feature: define MUX_GATE_ARB_STATS_EN to add one saturating
// 16-bit grant counter per requester and the grant_cnt output.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, at most one bit set
//   req_tt     per-requester truth table, slice i = [4*i +: 4]
//   req_a      per-requester operand A, slice i = [WIDTH*i +: WIDTH]
//   req_b      per-requester operand B, slice i = [WIDTH*i +: WIDTH]
//   rsp_valid  result valid
//   rsp_ready  consumer accepts the result
//   rsp_id     index of the requester owning rsp_data
//   grant_cnt  per-requester grant counters (MUX_GATE_ARB_STATS_EN only)
//   rsp_data   result
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and payload stable until that edge; ready may
// depend on valid but valid never waits on ready. req_ready is derived only
// from req_valid, rsp_ready and registered state, never from payload.
module mux_gate_arbiter
  import mux_gate_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*TT_W-1:0]   req_tt,
  input  logic [N_REQ*WIDTH-1:0]  req_a,
  input  logic [N_REQ*WIDTH-1:0]  req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
`ifdef MUX_GATE_ARB_STATS_EN
  output logic [N_REQ*CNT_W-1:0]  grant_cnt,
`endif
  output logic [WIDTH-1:0]        rsp_data
);

  // Round-robin pointer: index searched first on the next arbitration.
  logic [ID_W-1:0]  ptr;

  logic             take;
  logic             found;
  logic [ID_W-1:0]  gnt_idx;
  logic             accept;
  logic [ID_W-1:0]  ptr_next;
  int               scan_idx;

  logic [TT_W-1:0]  sel_tt;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] gate_y;

  // The output register can take a new result when it is empty or being
  // drained this very cycle; that is what removes the bubble.
  assign take = !rsp_valid || rsp_ready;

  // Search from ptr upward, wrapping; the first valid index wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(scan_idx);
      end
    end
  end

  // found already implies req_valid[gnt_idx], so accept needs no re-check.
  assign accept = found && take;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign ptr_next = ID_W'(wrap_inc(int'(gnt_idx), N_REQ));

  // Steer the granted requester's payload into the shared unit.
  assign sel_tt = req_tt[TT_W*gnt_idx +: TT_W];
  assign sel_a  = req_a[WIDTH*gnt_idx +: WIDTH];
  assign sel_b  = req_b[WIDTH*gnt_idx +: WIDTH];

  mux_logic_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .tt (sel_tt),
    .a  (sel_a),
    .b  (sel_b),
    .y  (gate_y)
  );

  // Output register and pointer. A stall (valid && !ready) falls through
  // every branch and so holds the response unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ptr       <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_data  <= gate_y;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MUX_GATE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (accept) begin
      // Saturate rather than wrap so a long-running count stays meaningful.
      if (cnt_q[gnt_idx] != {CNT_W{1'b1}}) begin
        cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt_out
    assign grant_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// tb_mux_gate_arbiter
// Directed and randomized bench for mux_gate_arbiter. A behavioural model
// tracks the pending requests, round-robin pointer and expected response.
module tb_mux_gate_arbiter;
  import mux_gate_arb_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ID_W = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*TT_W-1:0] req_tt;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_data;
`ifdef MUX_GATE_ARB_STATS_EN
  logic [N*CNT_W-1:0] grant_cnt;
`endif

  mux_gate_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tt    (req_tt),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef MUX_GATE_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .rsp_data  (rsp_data)
  );

  // ---------------- requester state ----------------
  logic [N-1:0]    v;
  logic [TT_W-1:0] v_tt [N];
  logic [W-1:0]    v_a  [N];
  logic [W-1:0]    v_b  [N];
  bit              refill;      // accepted requester immediately re-requests
  bit              chk_starve;  // check starvation bound on every grant
  int              wait_acc [N];

  // ---------------- reference model ----------------
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [W-1:0] m_data;
  int          m_cnt [N];
  int          last_g;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [TT_W-1:0] tt,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = tt[{b[k], a[k]}];
    return r;
  endfunction

  task automatic new_payload(input int i);
    v_tt[i] = TT_W'($urandom_range(0, 15));
    v_a[i]  = W'($urandom);
    v_b[i]  = W'($urandom);
  endtask

  task automatic drive();
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_tt[TT_W*i +: TT_W] = v_tt[i];
      req_a[W*i +: W]        = v_a[i];
      req_b[W*i +: W]        = v_b[i];
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_id    = 0;
    m_data  = '0;
    last_g  = -1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]    = 0;
      wait_acc[i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_id",    64'(rsp_id),    64'(m_id));
    check("rsp_data",  64'(rsp_data),  64'(m_data));
`ifdef MUX_GATE_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", 64'(grant_cnt[CNT_W*i +: CNT_W]),
            64'((m_cnt[i] > 65535) ? 65535 : m_cnt[i]));
`endif
  endtask

  // One clock: drive inputs, check req_ready, predict the edge, check outputs.
  task automatic step();
    bit           take;
    int           g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    take = !m_valid || rsp_ready;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int idx = (m_ptr + i) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0 && take) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (g >= 0 && take) begin
      m_data  = gate(v_tt[g], v_a[g], v_b[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
      m_cnt[g]++;
      last_g  = g;
      for (int i = 0; i < N; i++) if (v[i]) wait_acc[i]++;
      if (chk_starve) check("starve_bound", 64'(wait_acc[g] <= N), 64'd1);
      wait_acc[g] = 0;
      if (refill) new_payload(g);
      else v[g] = 1'b0;
    end else begin
      last_g = -1;
      if (rsp_ready) m_valid = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v   = '0;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  int seq [6] = '{0, 1, 2, 3, 0, 1};
  int prev_id;

  initial begin
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    refill     = 1'b0;
    chk_starve = 1'b0;
    v          = '0;
    for (int i = 0; i < N; i++) begin
      v_tt[i] = '0; v_a[i] = '0; v_b[i] = '0;
    end
    drive();
    @(negedge clk);
    do_reset();

    // Reset state with no requests.
    check_outputs();
    for (int c = 0; c < 3; c++) step();

    // Requester 2 alone, XOR.
    v[2] = 1'b1; v_tt[2] = TT_XOR; v_a[2] = 8'hF0; v_b[2] = 8'h3C;
    step();
    check("xor_valid", 64'(rsp_valid), 64'd1);
    check("xor_id",    64'(rsp_id),    64'd2);
    check("xor_data",  64'(rsp_data),  64'hCC);

    // All requesters valid, full throughput from a fresh pointer.
    do_reset();
    refill = 1'b1;
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; new_payload(i); end
    for (int c = 0; c < 6; c++) begin
      step();
      check("rr_seq", 64'(rsp_id), 64'(seq[c]));
    end

    // Stall for three cycles, then drain and accept together.
    prev_id   = int'(rsp_id);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rsp_ready = 1'b1;
    step();
    check("drain_valid", 64'(rsp_valid), 64'd1);
    check("drain_id",    64'(rsp_id),    64'((prev_id + 1) % N));

    // Gate functions on fixed operands.
    refill = 1'b0;
    v = '0;
    begin
      logic [TT_W-1:0] tts [4];
      logic [W-1:0]    res [4];
      tts = '{TT_AND, TT_OR, TT_NOR, TT_PASS_A};
      res = '{8'h05, 8'hAF, 8'h50, 8'hA5};
      for (int c = 0; c < 4; c++) begin
        v[1] = 1'b1; v_tt[1] = tts[c]; v_a[1] = 8'hA5; v_b[1] = 8'h0F;
        step();
        check("gate_data", 64'(rsp_data), 64'(res[c]));
      end
    end

    // Reset during a stall discards the pending response.
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; new_payload(i); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    do_reset();
    check_outputs();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; new_payload(i); end
    rsp_ready = 1'b1;
    step();
    check("rst_next_id", 64'(rsp_id), 64'd0);

    // Randomized traffic with back-pressure.
    v = '0;
    chk_starve = 1'b1;
    for (int i = 0; i < N; i++) wait_acc[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          new_payload(i);
          wait_acc[i] = 0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
